// File: rtl/sprite_addr_gen.sv
// Sprite address generator: double-buffered sprite descriptors (pending/active)
// with a once-per-frame commit, and four parallel mask-ROM address lanes
// registered one cycle behind the raster position.
module sprite_addr_gen #(
    parameter int          SPR_W            = 64,
    parameter int          SPR_H            = 64,
    parameter int          V_ACTIVE         = 480,
    parameter logic [16:0] TRANSPARENT_ADDR = 17'd0
) (
    input  logic          clk_25MHz,
    input  logic          rst_n,
    input  logic [9:0]    h_cnt,
    input  logic [9:0]    v_cnt,
    input  logic          video_valid,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [1:0]    wr_idx,
    input  logic [9:0]    wr_x,
    input  logic [9:0]    wr_y,
    input  logic [16:0]   wr_base,
    input  logic          wr_en,
    output logic [67:0]   addr,
    output logic          addr_valid,
    output logic          commit_done
);

    localparam int SHIFT_W = $clog2(SPR_W);

    typedef enum logic [1:0] {SCAN, COMMIT, BLANK} state_t;

    typedef struct packed {
        logic        en;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [16:0] base;
    } desc_t;

    state_t      state;
    state_t      state_next;
    desc_t       pending [4];
    desc_t       active  [4];
    logic        wr_fire;
    logic [67:0] addr_next;

    // Bounds are widened to 11 bits so a sprite near column/row 1023 never
    // wraps around to the left/top edge. SPR_W is a power of two, so the
    // row stride is a shift; the sum wraps naturally modulo 2^17.
    function automatic logic [16:0] slot_addr(input desc_t d,
                                              input logic [9:0] h,
                                              input logic [9:0] v);
        logic [10:0] x_end;
        logic [10:0] y_end;
        logic        hit;
        logic [9:0]  dx;
        logic [9:0]  dy;
        x_end = {1'b0, d.x} + 11'(SPR_W);
        y_end = {1'b0, d.y} + 11'(SPR_H);
        hit   = d.en
              && ({1'b0, h} >= {1'b0, d.x}) && ({1'b0, h} < x_end)
              && ({1'b0, v} >= {1'b0, d.y}) && ({1'b0, v} < y_end);
        dx    = h - d.x;
        dy    = v - d.y;
        if (hit)
            return d.base + (17'(dy) << SHIFT_W) + 17'(dx);
        else
            return TRANSPARENT_ADDR;
    endfunction

    // Host writes are refused only in the single commit cycle; held at 0 in reset.
    assign wr_ready    = rst_n && (state != COMMIT);
    assign wr_fire     = wr_valid && wr_ready;
    assign commit_done = (state == COMMIT);

    // Frame state register.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) state <= SCAN;
        else        state <= state_next;
    end

    // Next-state: commit once at the start of vertical blanking, re-arm at frame start.
    always_comb begin
        state_next = state;
        case (state)
            SCAN:    if (v_cnt == 10'(V_ACTIVE) && h_cnt == 10'd0) state_next = COMMIT;
            COMMIT:  state_next = BLANK;
            BLANK:   if (v_cnt == 10'd0 && h_cnt == 10'd0) state_next = SCAN;
            default: state_next = SCAN;
        endcase
    end

    // Descriptor banks: host fills pending; the commit cycle copies it to active.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            if (wr_fire)
                pending[wr_idx] <= '{en: wr_en, x: wr_x, y: wr_y, base: wr_base};
            if (state == COMMIT)
                for (int i = 0; i < 4; i++)
                    active[i] <= pending[i];
        end
    end

    // Per-slot address lookup against the active bank only.
    always_comb begin
        addr_next = '0;
        for (int i = 0; i < 4; i++)
            addr_next[17*i +: 17] = video_valid ? slot_addr(active[i], h_cnt, v_cnt)
                                                : TRANSPARENT_ADDR;
    end

    // Output register: one cycle of latency from the raster inputs.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= {4{TRANSPARENT_ADDR}};
            addr_valid <= 1'b0;
        end else begin
            addr       <= addr_next;
            addr_valid <= video_valid;
        end
    end

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Directed bench for sprite_addr_gen: hand-computed addresses for single,
// overlapping, deferred, colliding, edge-of-screen and wrap cases plus reset.
module tb_sprite_addr_gen;

    localparam logic [16:0] T  = 17'h00ABC;
    localparam int          VA = 480;

    logic        clk_25MHz = 1'b0;
    logic        rst_n     = 1'b0;
    logic [9:0]  h_cnt     = 10'd1;
    logic [9:0]  v_cnt     = 10'd1;
    logic        video_valid = 1'b0;
    logic        wr_valid  = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_idx    = 2'd0;
    logic [9:0]  wr_x      = 10'd0;
    logic [9:0]  wr_y      = 10'd0;
    logic [16:0] wr_base   = 17'd0;
    logic        wr_en     = 1'b0;
    logic [67:0] addr;
    logic        addr_valid;
    logic        commit_done;

    int n_cmp = 0;
    int n_err = 0;

    sprite_addr_gen #(
        .SPR_W(64), .SPR_H(64), .V_ACTIVE(VA), .TRANSPARENT_ADDR(T)
    ) dut (
        .clk_25MHz  (clk_25MHz),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .video_valid(video_valid),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_idx     (wr_idx),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_base    (wr_base),
        .wr_en      (wr_en),
        .addr       (addr),
        .addr_valid (addr_valid),
        .commit_done(commit_done)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic vv);
        h_cnt = h; v_cnt = v; video_valid = vv;
        step();
        h_cnt = 10'd1; v_cnt = 10'd1; video_valid = 1'b0;
    endtask

    task automatic write_desc(input logic [1:0] idx, input logic en, input logic [9:0] x,
                              input logic [9:0] y, input logic [16:0] base);
        bit done = 0;
        wr_idx = idx; wr_en = en; wr_x = x; wr_y = y; wr_base = base; wr_valid = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            done = wr_ready;
            step();
        end
        wr_valid = 1'b0;
        if (!done) chk("wr_accept_timeout", 68'd0, 68'd1);
    endtask

    task automatic commit();
        h_cnt = 10'd0; v_cnt = 10'(VA); video_valid = 1'b0;
        step();
        chk("commit_done_hi", 68'(commit_done), 68'd1);
        chk("wr_ready_commit", 68'(wr_ready), 68'd0);
        step();
        chk("commit_done_blank", 68'(commit_done), 68'd0);
        step();
        chk("no_second_commit", 68'(commit_done), 68'd0);
        h_cnt = 10'd0; v_cnt = 10'd0;
        step();
        h_cnt = 10'd1; v_cnt = 10'd1;
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_addr", addr, {4{T}});
        chk("rst_addr_valid", 68'(addr_valid), 68'd0);
        chk("rst_commit_done", 68'(commit_done), 68'd0);
        chk("rst_wr_ready", 68'(wr_ready), 68'd0);
        #5 rst_n = 1'b1;
        step();
        chk("wr_ready_scan", 68'(wr_ready), 68'd1);

        // Single sprite
        write_desc(2'd0, 1'b1, 10'd100, 10'd50, 17'h01000);
        pix(10'd100, 10'd50, 1'b1);
        chk("pending_not_active", addr, {4{T}});
        commit();
        pix(10'd100, 10'd50, 1'b1);
        chk("s0_topleft", addr, {T, T, T, 17'h01000});
        chk("addr_valid_1", 68'(addr_valid), 68'd1);
        pix(10'd163, 10'd113, 1'b1);
        chk("s0_botright", 68'(addr[16:0]), 68'h01FFF);
        pix(10'd164, 10'd50, 1'b1);
        chk("s0_right_miss", 68'(addr[16:0]), 68'(T));
        pix(10'd100, 10'd50, 1'b0);
        chk("vv_low_addr", addr, {4{T}});
        chk("vv_low_valid", 68'(addr_valid), 68'd0);

        // Overlap and deferred update
        write_desc(2'd1, 1'b1, 10'd200, 10'd60, 17'h02000);
        write_desc(2'd2, 1'b1, 10'd110, 10'd55, 17'h03000);
        commit();
        pix(10'd110, 10'd55, 1'b1);
        chk("overlap", addr, {T, 17'h03000, T, 17'h0114A});
        pix(10'd200, 10'd60, 1'b1);
        chk("s1_x200", addr, {T, T, 17'h02000, T});
        write_desc(2'd1, 1'b1, 10'd10, 10'd60, 17'h02000);
        pix(10'd200, 10'd60, 1'b1);
        chk("s1_still_200", 68'(addr[33:17]), 68'h02000);
        pix(10'd10, 10'd60, 1'b1);
        chk("s1_not_yet_10", 68'(addr[33:17]), 68'(T));
        commit();
        pix(10'd10, 10'd60, 1'b1);
        chk("s1_now_10", 68'(addr[33:17]), 68'h02000);
        pix(10'd200, 10'd60, 1'b1);
        chk("s1_old_gone", 68'(addr[33:17]), 68'(T));

        // Commit collision
        h_cnt = 10'd0; v_cnt = 10'(VA);
        step();
        wr_idx = 2'd3; wr_en = 1'b1; wr_x = 10'd300; wr_y = 10'd70; wr_base = 17'h04000;
        wr_valid = 1'b1;
        chk("coll_commit_done", 68'(commit_done), 68'd1);
        chk("coll_wr_ready_0", 68'(wr_ready), 68'd0);
        h_cnt = 10'd1;
        step();
        chk("coll_wr_ready_1", 68'(wr_ready), 68'd1);
        step();
        wr_valid = 1'b0;
        pix(10'd300, 10'd70, 1'b1);
        chk("coll_blank_miss", 68'(addr[67:51]), 68'(T));
        h_cnt = 10'd0; v_cnt = 10'd0;
        step();
        pix(10'd300, 10'd70, 1'b1);
        chk("coll_scan_miss", 68'(addr[67:51]), 68'(T));
        commit();
        pix(10'd300, 10'd70, 1'b1);
        chk("coll_next_frame", addr, {17'h04000, T, T, T});

        // Right-edge, no horizontal wrap
        write_desc(2'd0, 1'b1, 10'd1000, 10'd100, 17'h00000);
        commit();
        pix(10'd1020, 10'd100, 1'b1);
        chk("edge_dx20", 68'(addr[16:0]), 68'd20);
        pix(10'd1023, 10'd163, 1'b1);
        chk("edge_corner", 68'(addr[16:0]), 68'(17'd4055));
        pix(10'd5, 10'd100, 1'b1);
        chk("edge_nowrap", 68'(addr[16:0]), 68'(T));

        // Address wraps modulo 2^17
        write_desc(2'd0, 1'b1, 10'd400, 10'd200, 17'h1FFF0);
        commit();
        pix(10'd432, 10'd200, 1'b1);
        chk("base_wrap", 68'(addr[16:0]), 68'h00010);

        // Reset mid-frame
        h_cnt = 10'd432; v_cnt = 10'd200; video_valid = 1'b1;
        #7 rst_n = 1'b0;
        #1;
        chk("midrst_addr", addr, {4{T}});
        chk("midrst_wr_ready", 68'(wr_ready), 68'd0);
        step();
        #5 rst_n = 1'b1;
        step();
        pix(10'd432, 10'd200, 1'b1);
        chk("post_rst_s0", addr, {4{T}});
        pix(10'd10, 10'd60, 1'b1);
        chk("post_rst_s1", addr, {4{T}});
        commit();
        pix(10'd432, 10'd200, 1'b1);
        chk("post_rst_commit", addr, {4{T}});
        write_desc(2'd0, 1'b1, 10'd400, 10'd200, 17'h1FFF0);
        commit();
        pix(10'd432, 10'd200, 1'b1);
        chk("post_rst_rewrite", addr, {T, T, T, 17'h00010});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_addr_gen.md
SPRITE_ADDR_GEN -- requirements
Module: sprite_addr_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_25MHz (in, 1) is the single clock, rising edge; rst_n (in, 1) is the active-low reset, asserted asynchronously.
REQ-002 The block SHALL have parameter SPR_W, default 64, sprite width in pixels (power of two).
REQ-003 The block SHALL have parameter SPR_H, default 64, sprite height in pixels (power of two).
REQ-004 The block SHALL have parameter V_ACTIVE, default 480, the first blanking line.
REQ-005 The block SHALL have parameter TRANSPARENT_ADDR, default 17'd0, a mask-ROM address holding 0.
REQ-006 The block SHALL have these ports, in this order after clk_25MHz and rst_n:
- h_cnt, in, 10: current pixel column.
- v_cnt, in, 10: current pixel row.
- video_valid, in, 1: current pixel is in the visible area.
- wr_valid, in, 1: sprite-descriptor write request.
- wr_ready, out, 1: write is accepted this cycle when wr_valid && wr_ready.
- wr_idx, in, 2: sprite slot 0..3.
- wr_x, in, 10: sprite left column.
- wr_y, in, 10: sprite top row.
- wr_base, in, 17: sprite image base address.
- wr_en, in, 1: sprite enable.
- addr, out, 68: slot i address in bits [17i+16:17i]; slot 0 is the highest priority.
- addr_valid, out, 1: registered copy of video_valid, aligned with addr.
- commit_done, out, 1: one-cycle pulse when descriptors go active.

Function
REQ-007 The block SHALL hold two descriptor banks: pending (written by the host) and active (used for address generation); each entry is {en, x, y, base}.
REQ-008 An accepted write SHALL update pending[wr_idx] at that clock edge; repeated writes to one slot before a commit SHALL mean the last write wins.
REQ-009 The FSM SHALL have three states: SCAN, COMMIT and BLANK.
- SCAN -> COMMIT when v_cnt==V_ACTIVE && h_cnt==0.
- COMMIT -> BLANK unconditionally after 1 cycle.
- BLANK -> SCAN when v_cnt==0 && h_cnt==0.
REQ-010 In COMMIT, all four pending entries SHALL be copied to active, and commit_done SHALL be 1 for exactly that cycle; there SHALL be exactly one commit per frame.
REQ-011 wr_ready SHALL be 0 in COMMIT and 1 in SCAN and BLANK; a wr_valid request during COMMIT SHALL NOT be accepted and the host holds it until the next cycle.
REQ-012 Slot i SHALL hit when all of the following are true:
- active[i].en is 1;
- x <= h_cnt < x+SPR_W;
- y <= v_cnt < y+SPR_H.
REQ-013 The comparison bounds SHALL be computed in 11 bits, so that a sprite near column or row 1023 does not wrap to column or row 0.
REQ-014 On a hit, with dx=h_cnt-x and dy=v_cnt-y, slot address SHALL be base + dy*SPR_W + dx, computed modulo 2^17.
REQ-015 On a miss, or when video_valid is 0, the slot address SHALL be TRANSPARENT_ADDR.
REQ-016 addr and addr_valid SHALL be registered, giving a latency of exactly 1 cycle from h_cnt, v_cnt and video_valid.
REQ-017 Address generation SHALL read only the active bank; pending writes SHALL NOT affect addr before the next COMMIT.
REQ-018 Slots SHALL be independent; overlapping sprites SHALL all produce hit addresses, and priority is resolved downstream.

Reset
REQ-019 While rst_n is 0, the block SHALL hold the following values:
- FSM = SCAN;
- all pending and active entries = {0,0,0,0};
- addr = {4{TRANSPARENT_ADDR}};
- addr_valid = 0, commit_done = 0, wr_ready = 0.
REQ-020 A reset asserted mid-frame or during COMMIT SHALL discard all pending and active descriptors; after release, the first commit occurs at the next SCAN->COMMIT transition.

Verification
REQ-021 Single sprite: write slot0 {en=1, x=100, y=50, base=17'h1000}, then run through a commit. Sample (h,v)=(100,50) -> addr[16:0]=17'h1000 one cycle later; (163,113) -> 17'h1FFF; (164,50) -> TRANSPARENT_ADDR.
REQ-022 Deferred update: write slot1 {x=10} mid-frame while the active x=200. For the rest of the frame slot1 still hits at x=200; after commit_done it hits at x=10.
REQ-023 Commit collision: wr_valid is held high across the SCAN->COMMIT cycle -> wr_ready=0 in COMMIT and the write is accepted in the first BLANK cycle. That value appears in active only after the following frame's commit.
REQ-024 Edge and overflow case 1: sprite x=1000, width 64, at h=1020 -> hit with dx=20; at h=5 -> miss (no wrap).
REQ-025 Edge and overflow case 2: base=17'h1FFF0, dy=0, dx=0x20 -> addr=17'h00010.
REQ-026 Reset mid-frame: assert rst_n=0 with slots enabled -> addr={4{TRANSPARENT_ADDR}}, and after release there are no hits until a write and a commit.
